// File: rtl/baby_mem_pkg.sv
// baby_mem_pkg
// Shared types and constants for the Manchester Baby external memory bridge.
// Contents: bridge FSM state enum, word/byte geometry, command byte layout,
// read/write encoding shared with the core's RAM port, command byte builder.
package baby_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_TURN,
    ST_RDATA,
    ST_DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  // Command byte: {rw, pad, addr}
  localparam int CMD_ADDR_W = 5;
  localparam int CMD_PAD_W  = 2;
  localparam int CMD_RW_BIT = CMD_PAD_W + CMD_ADDR_W;

  // Same encoding as the core's ram_rw_en_o
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  function automatic logic [7:0] make_cmd(input logic rw,
                                          input logic [CMD_ADDR_W-1:0] addr);
    logic [7:0] c;
    c                 = '0;
    c[CMD_RW_BIT]     = rw;
    c[CMD_ADDR_W-1:0] = addr;
    return c;
  endfunction

endpackage

// File: rtl/baby_byte_lane.sv
// baby_byte_lane
// 32-bit word <-> byte converter used by the bridge for both directions.
// Ports:
//   clk, srst      clock, synchronous active-high reset
//   load/load_word capture a whole word (write data from the core)
//   shift_en/shift_byte/idx  write one received byte into byte[idx]
//   rd_idx/cur_byte          byte currently selected for transmission
//   merged         stored word with byte[idx] replaced by shift_byte, so the
//                  final read beat can be returned without waiting a cycle
module baby_byte_lane
  import baby_mem_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [31:0]      load_word,
  input  logic             shift_en,
  input  logic [7:0]       shift_byte,
  input  logic [IDX_W-1:0] idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      merged,
  output logic [7:0]       cur_byte
);

  logic [31:0] word_reg;

  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_byte
    assign merged[gi*8 +: 8] = (idx == IDX_W'(gi)) ? shift_byte : word_reg[gi*8 +: 8];
  end

  assign cur_byte = word_reg[rd_idx*8 +: 8];

  always_ff @(posedge clk) begin
    if (srst) begin
      word_reg <= '0;
    end else if (load) begin
      word_reg <= load_word;
    end else if (shift_en) begin
      word_reg <= merged;
    end
  end

endmodule

// File: rtl/baby_mem_bridge.sv
// baby_mem_bridge
// Converts 32-bit core word accesses into byte-serial transactions on an
// 8-bit strobe/ready bus: a command byte, then four data bytes LSB first
// (with a one-cycle turnaround before read data). Every access ends with a
// one-cycle ack; a beat stalled for TIMEOUT_CYCLES aborts the access and
// sets a sticky timeout flag.
// Ports:
//   clock, reset_i              clock, synchronous active-high reset
//   core_req/rw/addr/data_i     core request (held until ack)
//   core_data_o, core_ack_o     last completed read word, completion pulse
//   timeout_o                   sticky abort indicator
//   ext_data_o/i, ext_oe_o      external byte bus and drive enable
//   ext_strobe_o, ext_ready_i   beat handshake
// All outputs are registered; they are set up on the edge entering a state.
module baby_mem_bridge
  import baby_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_i,
  input  logic        core_req_i,
  input  logic        core_rw_i,
  input  logic [4:0]  core_addr_i,
  input  logic [31:0] core_data_i,
  output logic [31:0] core_data_o,
  output logic        core_ack_o,
  output logic        timeout_o,
  output logic [7:0]  ext_data_o,
  input  logic [7:0]  ext_data_i,
  output logic        ext_oe_o,
  output logic        ext_strobe_o,
  input  logic        ext_ready_i
);

  state_t           state_reg;
  logic             rw_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       tmo_cnt_reg;

  logic             beat;
  logic             stall;
  logic             abort;
  logic             lane_load;
  logic             lane_shift;
  logic [IDX_W-1:0] lane_rd_idx;
  logic [31:0]      lane_merged;
  logic [7:0]       lane_byte;

  // Strobe is only ever high in CMD/WDATA/RDATA, so ready is ignored elsewhere.
  assign beat  = ext_strobe_o & ext_ready_i;
  assign stall = ext_strobe_o & ~ext_ready_i;
  // This stall would be the TIMEOUT_CYCLES-th consecutive one on the beat.
  assign abort = stall && (tmo_cnt_reg == 8'(TIMEOUT_CYCLES - 1));

  assign lane_load  = (state_reg == ST_IDLE) && core_req_i;
  assign lane_shift = (state_reg == ST_RDATA) && beat;
  // Look one byte ahead so the next data byte is registered on the beat edge.
  assign lane_rd_idx = (state_reg == ST_WDATA) ? idx_reg + 2'd1 : 2'd0;

  baby_byte_lane u_lane (
    .clk        (clock),
    .srst       (reset_i),
    .load       (lane_load),
    .load_word  (core_data_i),
    .shift_en   (lane_shift),
    .shift_byte (ext_data_i),
    .idx        (idx_reg),
    .rd_idx     (lane_rd_idx),
    .merged     (lane_merged),
    .cur_byte   (lane_byte)
  );

  always_ff @(posedge clock) begin
    if (reset_i) begin
      state_reg    <= ST_IDLE;
      rw_reg       <= RW_READ;
      idx_reg      <= '0;
      tmo_cnt_reg  <= '0;
      core_data_o  <= '0;
      core_ack_o   <= 1'b0;
      timeout_o    <= 1'b0;
      ext_data_o   <= '0;
      ext_oe_o     <= 1'b0;
      ext_strobe_o <= 1'b0;
    end else begin
      core_ack_o <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (core_req_i) begin
            rw_reg       <= core_rw_i;
            idx_reg      <= '0;
            tmo_cnt_reg  <= '0;
            ext_data_o   <= make_cmd(core_rw_i, core_addr_i);
            ext_oe_o     <= 1'b1;
            ext_strobe_o <= 1'b1;
            state_reg    <= ST_CMD;
          end
        end

        ST_CMD, ST_WDATA, ST_RDATA: begin
          if (beat) begin
            tmo_cnt_reg <= '0;
            if (state_reg == ST_CMD) begin
              if (rw_reg == RW_WRITE) begin
                ext_data_o <= lane_byte;
                state_reg  <= ST_WDATA;
              end else begin
                ext_oe_o     <= 1'b0;
                ext_strobe_o <= 1'b0;
                state_reg    <= ST_TURN;
              end
            end else if (idx_reg == LAST_IDX) begin
              if (state_reg == ST_RDATA) begin
                core_data_o <= lane_merged;
              end
              ext_oe_o     <= 1'b0;
              ext_strobe_o <= 1'b0;
              core_ack_o   <= 1'b1;
              state_reg    <= ST_DONE;
            end else begin
              idx_reg <= idx_reg + 2'd1;
              if (state_reg == ST_WDATA) begin
                ext_data_o <= lane_byte;
              end
            end
          end else if (abort) begin
            tmo_cnt_reg  <= '0;
            timeout_o    <= 1'b1;
            ext_oe_o     <= 1'b0;
            ext_strobe_o <= 1'b0;
            core_ack_o   <= 1'b1;
            state_reg    <= ST_DONE;
          end else if (stall) begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
          end
        end

        ST_TURN: begin
          idx_reg      <= '0;
          tmo_cnt_reg  <= '0;
          ext_strobe_o <= 1'b1;
          state_reg    <= ST_RDATA;
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baby_mem_bridge.sv
// tb_baby_mem_bridge
// Directed bench for baby_mem_bridge (TIMEOUT_CYCLES=4). Cycle 0 is the first
// IDLE cycle seeing a request; outputs are sampled 1 ns after each rising edge.
module tb_baby_mem_bridge;

  logic        clock = 1'b0;
  logic        reset_i;
  logic        core_req_i;
  logic        core_rw_i;
  logic [4:0]  core_addr_i;
  logic [31:0] core_data_i;
  logic [31:0] core_data_o;
  logic        core_ack_o;
  logic        timeout_o;
  logic [7:0]  ext_data_o;
  logic [7:0]  ext_data_i;
  logic        ext_oe_o;
  logic        ext_strobe_o;
  logic        ext_ready_i;

  int checks   = 0;
  int failures = 0;

  logic [39:0] wv;
  logic [31:0] wd;

  always #5 clock = ~clock;

  baby_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clock        (clock),
    .reset_i      (reset_i),
    .core_req_i   (core_req_i),
    .core_rw_i    (core_rw_i),
    .core_addr_i  (core_addr_i),
    .core_data_i  (core_data_i),
    .core_data_o  (core_data_o),
    .core_ack_o   (core_ack_o),
    .timeout_o    (timeout_o),
    .ext_data_o   (ext_data_o),
    .ext_data_i   (ext_data_i),
    .ext_oe_o     (ext_oe_o),
    .ext_strobe_o (ext_strobe_o),
    .ext_ready_i  (ext_ready_i)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic s, input logic o, input logic a);
    chk({tag, "_strobe"}, {31'd0, ext_strobe_o}, {31'd0, s});
    chk({tag, "_oe"},     {31'd0, ext_oe_o},     {31'd0, o});
    chk({tag, "_ack"},    {31'd0, core_ack_o},   {31'd0, a});
  endtask

  // Read with ready high: CMD c1, TURN c2, RDATA c3..c6, ack c7.
  task automatic do_read(input string tag, input logic [4:0] addr, input logic [31:0] word);
    core_req_i  = 1'b1;
    core_rw_i   = 1'b0;
    core_addr_i = addr;
    ext_ready_i = 1'b1;
    tick();
    bus({tag, "_cmd"}, 1'b1, 1'b1, 1'b0);
    chk({tag, "_cmdbyte"}, {24'd0, ext_data_o}, {24'd0, 3'b000, addr});
    tick();
    bus({tag, "_turn"}, 1'b0, 1'b0, 1'b0);
    chk({tag, "_turnhold"}, {24'd0, ext_data_o}, {24'd0, 3'b000, addr});
    for (int k = 0; k < 4; k++) begin
      tick();
      ext_data_i = word[8*k +: 8];
      bus({tag, "_rdata"}, 1'b1, 1'b0, 1'b0);
    end
    tick();
    bus({tag, "_done"}, 1'b0, 1'b0, 1'b1);
    chk({tag, "_word"}, core_data_o, word);
    core_req_i = 1'b0;
    tick();
    bus({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_i     = 1'b1;
    core_req_i  = 1'b0;
    core_rw_i   = 1'b0;
    core_addr_i = '0;
    core_data_i = '0;
    ext_data_i  = '0;
    ext_ready_i = 1'b0;
    tick();
    tick();
    bus("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_core_data", core_data_o, 32'h0);
    chk("rst_timeout", {31'd0, timeout_o}, 32'h0);
    chk("rst_ext_data", {24'd0, ext_data_o}, 32'h0);
    reset_i = 1'b0;
    tick();

    // Write, ready high: cmd 0x9F then EF BE AD DE, ack at +6
    core_req_i  = 1'b1;
    core_rw_i   = 1'b1;
    core_addr_i = 5'h1F;
    core_data_i = 32'hDEADBEEF;
    ext_ready_i = 1'b1;
    wv = 40'h9F_EF_BE_AD_DE;
    for (int k = 0; k < 5; k++) begin
      tick();
      bus("wr_beat", 1'b1, 1'b1, 1'b0);
      chk("wr_byte", {24'd0, ext_data_o}, {24'd0, wv[39-8*k -: 8]});
    end
    tick();
    bus("wr_done", 1'b0, 1'b0, 1'b1);
    chk("wr_core_data_kept", core_data_o, 32'h0);
    core_req_i = 1'b0;
    tick();
    bus("wr_idle", 1'b0, 1'b0, 1'b0);

    // Read, ready high
    do_read("rd", 5'h05, 32'h12345678);

    // Back-pressure write: each data beat stalled 3 cycles, ack at +18
    core_req_i  = 1'b1;
    core_rw_i   = 1'b1;
    core_addr_i = 5'h0A;
    core_data_i = 32'h11223344;
    ext_ready_i = 1'b1;
    tick();
    bus("bp_cmd", 1'b1, 1'b1, 1'b0);
    chk("bp_cmdbyte", {24'd0, ext_data_o}, 32'h8A);
    wd = 32'h11223344;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < 4; s++) begin
        tick();
        ext_ready_i = (s == 3);
        bus("bp_beat", 1'b1, 1'b1, 1'b0);
        chk("bp_byte", {24'd0, ext_data_o}, {24'd0, wd[8*b +: 8]});
      end
    end
    tick();
    bus("bp_done", 1'b0, 1'b0, 1'b1);
    chk("bp_timeout_clear", {31'd0, timeout_o}, 32'h0);
    chk("bp_core_data_kept", core_data_o, 32'h12345678);
    core_req_i = 1'b0;
    tick();

    // Timeout: read with ready low, abort after 4 CMD cycles
    core_req_i  = 1'b1;
    core_rw_i   = 1'b0;
    core_addr_i = 5'h03;
    ext_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      bus("to_stall", 1'b1, 1'b1, 1'b0);
      chk("to_not_yet", {31'd0, timeout_o}, 32'h0);
    end
    tick();
    bus("to_done", 1'b0, 1'b0, 1'b1);
    chk("to_flag", {31'd0, timeout_o}, 32'h1);
    chk("to_core_data_kept", core_data_o, 32'h12345678);
    core_req_i = 1'b0;
    tick();
    bus("to_idle", 1'b0, 1'b0, 1'b0);
    chk("to_sticky", {31'd0, timeout_o}, 32'h1);
    do_read("to_next", 5'h07, 32'hCAFEF00D);
    chk("to_sticky2", {31'd0, timeout_o}, 32'h1);

    // Reset during WDATA idx=2 beat
    core_req_i  = 1'b1;
    core_rw_i   = 1'b1;
    core_addr_i = 5'h11;
    core_data_i = 32'h55667788;
    ext_ready_i = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("mr_idx2_byte", {24'd0, ext_data_o}, 32'h66);
    reset_i    = 1'b1;
    core_req_i = 1'b0;
    tick();
    bus("mr_reset", 1'b0, 1'b0, 1'b0);
    chk("mr_ext_data", {24'd0, ext_data_o}, 32'h0);
    chk("mr_core_data", core_data_o, 32'h0);
    chk("mr_timeout", {31'd0, timeout_o}, 32'h0);
    reset_i = 1'b0;
    tick();
    do_read("mr_read", 5'h09, 32'hA5A5A5A5);

    // Held request: second write starts from the IDLE cycle after DONE
    core_req_i  = 1'b1;
    core_rw_i   = 1'b1;
    core_addr_i = 5'h02;
    core_data_i = 32'h01020304;
    ext_ready_i = 1'b1;
    wv = 40'h82_04_03_02_01;
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 5; k++) begin
        tick();
        bus("hd_beat", 1'b1, 1'b1, 1'b0);
        chk("hd_byte", {24'd0, ext_data_o}, {24'd0, wv[39-8*k -: 8]});
      end
      tick();
      bus("hd_done", 1'b0, 1'b0, 1'b1);
      tick();
      bus("hd_gap", 1'b0, 1'b0, 1'b0);
    end
    core_req_i = 1'b0;
    tick();
    bus("hd_final_idle", 1'b0, 1'b0, 1'b0);
    chk("hd_core_data_kept", core_data_o, 32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/baby_mem_bridge.md
Name: baby_mem_bridge

Overview:
Sits directly downstream of the manchester_baby core's RAM port. It turns each 32-bit word access (5-bit address, read/write) into a byte-serial transaction on an 8-bit external memory bus with a strobe/ready handshake. It returns assembled read words to the core and acknowledges every access, so the core's 32-word store can live off-chip behind a narrow pin budget.

Parameters:
TIMEOUT_CYCLES, 255, max cycles a single beat may wait for ext_ready_i before the access is aborted (1..255).

Ports:
clock  input  1  system clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
core_req_i  input  1  core access request; held high and stable until core_ack_o
core_rw_i  input  1  0 = read, 1 = write (same encoding as ram_rw_en_o)
core_addr_i  input  5  word address
core_data_i  input  32  write word
core_data_o  output  32  last completed read word
core_ack_o  output  1  one-cycle pulse: access finished (or aborted)
timeout_o  output  1  sticky: an access was aborted by timeout
ext_data_o  output  8  byte driven onto external bus
ext_data_i  input  8  byte sampled from external bus
ext_oe_o  output  1  1 = bridge drives bus
ext_strobe_o  output  1  beat valid/requested
ext_ready_i  input  1  external side accepts/provides beat

Behaviour:
- Reset (sync, wins over everything, including mid-transaction): state IDLE; core_data_o=0, core_ack_o=0, timeout_o=0, ext_data_o=0, ext_oe_o=0, ext_strobe_o=0; beat index and timeout counter cleared.
- A beat completes on any cycle where ext_strobe_o=1 and ext_ready_i=1.
- States: IDLE, CMD, WDATA, TURN, RDATA, DONE.
- IDLE: if core_req_i=1, latch core_rw_i, core_addr_i, core_data_i -> CMD. Otherwise stay.
- CMD: oe=1, strobe=1, ext_data_o = {rw, 2'b00, addr[4:0]}. On beat complete -> WDATA if rw=1, else TURN.
- WDATA: oe=1, strobe=1, ext_data_o = latched word byte[idx], with idx 0..3 (LSB byte first). Each completed beat increments idx. Completion of the idx=3 beat -> DONE.
- TURN: one cycle with oe=0, strobe=0 (bus turnaround) -> RDATA.
- RDATA: oe=0, strobe=1. On each completed beat, sample ext_data_i into byte[idx] of a shift register. Completion of the idx=3 beat -> DONE, and core_data_o loads the assembled word on that same edge.
- DONE: core_ack_o=1 for exactly this cycle; strobe=0, oe=0 -> IDLE. core_req_i is ignored in DONE. The core must drop the request on seeing ack. If core_req_i is still high in the following IDLE cycle, that is treated as a new request.
- Latency with ext_ready_i tied high, counted from the first IDLE cycle seeing the request: write ack at cycle +6; read ack at cycle +7.
- Timeout: the counter increments on each cycle with strobe=1 and ready=0, and clears on beat completion or state change. When it reaches TIMEOUT_CYCLES, go to DONE and set timeout_o (sticky until reset). core_data_o is unchanged on an aborted read.
- core_data_o is updated only by a completed read and is unchanged by writes.
- ext_data_o holds its last driven value while oe=0.
- ext_ready_i is ignored outside CMD, WDATA and RDATA.
- All outputs are registered.

Decomposition:
- Package baby_mem_pkg:
  - state enum
  - BYTES_PER_WORD=4
  - CMD_RW_BIT=7
  - command byte field widths
  - RW_READ/RW_WRITE constants, shared with manchester_baby
- One natural sub-module: baby_byte_lane, a 32-bit word<->byte shift register with load-word, shift-in-byte and current-byte outputs, indexed by beat count.

Test Plan:
- Write, ready tied high: req rw=1, addr=0x1F, data=0xDEADBEEF -> bytes 0x9F, EF, BE, AD, DE on consecutive strobes; ack at +6; oe=1 throughout; core_data_o stays 0.
- Read, ready tied high: req rw=0, addr=0x05; external model returns 0x78, 56, 34, 12 -> cmd byte 0x05; one TURN cycle with oe=0, strobe=0; ack at +7; core_data_o=0x12345678.
- Back-pressure: write with ready low for 3 cycles on each data beat -> each byte held stable while stalled; no byte skipped or repeated; ack at +18.
- Timeout: TIMEOUT_CYCLES=4, read with ready held low -> abort 4 cycles into CMD; ack pulses; timeout_o=1 and remains set; core_data_o unchanged; next access completes normally.
- Reset mid-transaction: assert reset_i during the WDATA idx=2 beat -> next cycle IDLE, all outputs 0, timeout_o cleared; a subsequent read of 0xA5A5A5A5 completes correctly.
- Held request: keep core_req_i high through ack -> a second full transaction starts in the IDLE cycle after DONE, with no spurious beats in between.
